// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU result checker: op codes, FSM encoding, result payload.
package alu_chk_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2,
        OP_ADD = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    // One ALU outcome: result plus flags, compared as a single word
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              z;
        logic              cf;
    } alu_res_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU (AND/OR/XOR/ADD) with zero and carry flags.
module alu_ref_model
    import alu_chk_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] exp_out,
    output logic              exp_z,
    output logic              exp_cf
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum     = {1'b0, in1} + {1'b0, in2};
        exp_out = '0;
        exp_cf  = 1'b0;
        unique case (alu_op_e'(op))
            OP_AND:  exp_out = in1 & in2;
            OP_OR:   exp_out = in1 | in2;
            OP_XOR:  exp_out = in1 ^ in2;
            OP_ADD:  {exp_cf, exp_out} = sum;
            default: exp_out = '0;
        endcase
        exp_z = (exp_out == '0);
    end

endmodule

// File: rtl/alu_result_checker.sv
// Checks ALU results against a reference model over a run of VEC_COUNT vectors.
// Define CHECKER_STOP_ON_FAIL_EN to end a run on the first mismatching sample.
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int unsigned VEC_COUNT = 7,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] out,
    input  logic              z,
    input  logic              cf,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              done,
    output logic              err_valid,
    output logic [CNT_W-1:0]  err_idx,
    output logic [DATA_W-1:0] err_out,
    output logic [DATA_W-1:0] err_exp
);

    localparam int unsigned      IDX_W    = (VEC_COUNT < 2) ? 1 : $clog2(VEC_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef CHECKER_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    chk_state_e        state, state_d;
    logic [IDX_W-1:0]  vec_idx;
    alu_res_t          exp_r, obs_r;
    logic              accept, mismatch;
    logic              run_clear, run_finish;

    alu_ref_model u_ref (
        .op      (op),
        .in1     (in1),
        .in2     (in2),
        .exp_out (exp_r.res),
        .exp_z   (exp_r.z),
        .exp_cf  (exp_r.cf)
    );

    assign obs_r    = '{res: out, z: z, cf: cf};
    assign mismatch = (obs_r != exp_r);
    assign accept   = in_valid && in_ready;

    // Next-state and run control strobes
    always_comb begin
        state_d    = state;
        run_clear  = 1'b0;
        run_finish = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    run_clear = 1'b1;
                end
            end
            RUN: begin
                if (accept && ((vec_idx == LAST_IDX) || (STOP_ON_FAIL && mismatch))) begin
                    state_d    = DONE;
                    run_finish = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Handshake, completion flag and vector index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            done     <= 1'b0;
            vec_idx  <= '0;
        end else begin
            in_ready <= (state_d == RUN);
            if (run_clear) begin
                done    <= 1'b0;
                vec_idx <= '0;
            end else begin
                if (run_finish) begin
                    done <= 1'b1;
                end
                if (accept) begin
                    vec_idx <= vec_idx + IDX_W'(1);
                end
            end
        end
    end

    // Saturating pass/fail counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (run_clear) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (accept) begin
            if (mismatch) begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
            end else begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
            end
        end
    end

    // First-failure record; held once valid until the next run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_idx   <= '0;
            err_out   <= '0;
            err_exp   <= '0;
        end else if (run_clear) begin
            err_valid <= 1'b0;
            err_idx   <= '0;
            err_out   <= '0;
            err_exp   <= '0;
        end else if (accept && mismatch && !err_valid) begin
            err_valid <= 1'b1;
            err_idx   <= CNT_W'(vec_idx);
            err_out   <= out;
            err_exp   <= exp_r.res;
        end
    end

endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 SHALL have parameter VEC_COUNT, default 7, number of vectors per run.
REQ-002 SHALL have parameter CNT_W, default 8, width of pass/fail counters.
REQ-003 SHALL have: clk  input  1  single clock, rising edge.
REQ-004 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have: start  input  1  one-cycle pulse, begins a run.
REQ-006 SHALL have: in_valid  input  1  sample present; in_ready  output  1  checker accepts sample.
REQ-007 SHALL have: op  input  2  operation code (AND, OR, XOR, ADD).
REQ-008 SHALL have: in1, in2  input  4  operands driven to the ALU under test.
REQ-009 SHALL have: out  input  4  ALU result; z  input  1  ALU zero flag; cf  input  1  ALU carry flag.
REQ-010 SHALL have: pass_cnt, fail_cnt  output  CNT_W  run counters; done  output  1  run complete.
REQ-011 SHALL have: err_valid  output  1  first-failure record valid; err_idx  output  CNT_W  vector index of first failure; err_out  output  4  captured result; err_exp  output  4  expected result.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL move IDLE->RUN and DONE->RUN on start, clearing counters, err_* and done on that edge.
REQ-014 SHALL ignore start while in RUN.
REQ-015 SHALL drive in_ready=1 only in RUN; a sample is accepted on an edge with in_valid && in_ready.
REQ-016 SHALL compute expected: AND/OR/XOR bitwise with expected cf=0; ADD {cf,res}=in1+in2 (5-bit); expected z=1 iff expected res==4'b0000.
REQ-017 SHALL flag mismatch if out, z or cf differs from expected.
REQ-018 SHALL update pass_cnt or fail_cnt on the accepting edge (visible next cycle, latency 1).
REQ-019 SHALL saturate both counters at 2^CNT_W-1, no wrap.
REQ-020 SHALL, on the first mismatch of a run, latch err_idx (0-based accept index), err_out, err_exp and set err_valid; later mismatches SHALL NOT overwrite.
REQ-021 SHALL move RUN->DONE on the edge accepting vector VEC_COUNT, asserting done on that edge; in_ready=0 in DONE.
REQ-022 SHALL hold counters, err_* and done stable in DONE until start.

Reset
REQ-023 SHALL on rst_n low, immediately and independent of clk: state IDLE, in_ready=0, done=0, pass_cnt=0, fail_cnt=0, err_valid=0, err_idx=0, err_out=0, err_exp=0.
REQ-024 SHALL discard any in-progress run on reset; no partial count survives.

Configuration
REQ-025 SHALL support macro CHECKER_STOP_ON_FAIL_EN.
REQ-026 With CHECKER_STOP_ON_FAIL_EN defined, SHALL move RUN->DONE on the edge accepting the first mismatching sample, asserting done there.
REQ-027 Without it, SHALL run all VEC_COUNT vectors regardless of mismatches.

Structure
REQ-028 SHALL place op codes (AND=0, OR=1, XOR=2, ADD=3) and the FSM state encoding in shared package alu_chk_pkg.
REQ-029 SHALL instantiate one combinational sub-module alu_ref_model (op, in1, in2 -> exp_out, exp_z, exp_cf).

Verification
REQ-030 Run, op=AND, seven vectors (0000/0000, 1111/0000, 0000/1111, 1100/0011, 1001/0011, 0100/1111, 1111/1111) with correct DUT -> pass_cnt=7, fail_cnt=0, done=1, err_valid=0.
REQ-031 Same run, vector 4 (1001&0011) reports out=0000, z=1 -> fail_cnt=1, pass_cnt=6, err_idx=4, err_out=0000, err_exp=0001; with CHECKER_STOP_ON_FAIL_EN, done at vector 4, pass_cnt=4.
REQ-032 op=ADD, 1111+0001, out=0000, z=1, cf=1 -> pass; same with cf=0 -> fail.
REQ-033 CNT_W=2, VEC_COUNT=6 all passing -> pass_cnt saturates at 3, done=1.
REQ-034 rst_n low after 3 accepted vectors -> all outputs 0, state IDLE immediately; in_valid held high with no start -> in_ready stays 0, counters stay 0.
REQ-035 start pulsed in RUN -> counters unchanged; start in DONE -> counters and err_* cleared next cycle, in_ready=1.
